execute_stage: RTL
==================

# execute_stage

Execute stage of the 5-stage MIPS pipeline, directly downstream of the decode/execute pipeline register. It selects forwarded operands, computes the ALU result, and selects the destination register. It also contains an iterative signed multiply/divide unit with HI/LO registers. While a MULT/DIV is in flight it raises a stall to the hazard unit.

## Interface
Parameters:
- WIDTH, 32, datapath width; only 32 is supported.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low
- ALUControlE  in  4  operation code from the decode/execute register
- ALUSrcE  in  1  1 selects SignImmE as operand B
- RegDstE  in  1  1 selects RdE as write register, 0 selects RtE
- RD1_E, RD2_E  in  32  register-file read data
- RtE, RdE  in  5  register specifiers
- SignImmE  in  32  sign-extended immediate
- ForwardAE, ForwardBE  in  2  forwarding selects: 00 = RDx_E, 10 = ALUOutM, 01 = ResultW, 11 = RDx_E
- ALUOutM  in  32  memory-stage ALU result
- ResultW  in  32  writeback result
- ALUOutE  out  32  combinational ALU result
- WriteDataE  out  32  forwarded operand B, before the ALUSrc mux
- WriteRegE  out  5  destination register
- StallE  out  1  multiply/divide busy; hazard unit holds stages F, D and E
- HiE, LoE  out  32  current HI/LO register values

## Operation
- SrcA = fwd(ForwardAE, RD1_E). WriteDataE = fwd(ForwardBE, RD2_E). SrcB = ALUSrcE ? SignImmE : WriteDataE.
- ALU codes:
  - 0 AND, 1 OR, 2 ADD, 3 XOR, 4 NOR, 6 SUB, 7 SLT (signed, result 0/1).
  - 8 MULT, 9 DIV, A MFHI (ALUOutE=HI), B MFLO (ALUOutE=LO).
  - Codes 5, C–F give ALUOutE=0.
  - ADD/SUB wrap modulo 2^32; no overflow trap.
- ALUOutE is 0 for MULT/DIV.
- FSM states IDLE, BUSY, DONE; 5-bit iteration counter.
- IDLE:
  - If the code is MULT or DIV, StallE=1.
  - On the next edge, latch |SrcA|, |SrcB| and the result signs; go to BUSY with count=0.
- BUSY:
  - One shift-add (MULT) or restoring shift-subtract (DIV) step per cycle; StallE=1.
  - After the step with count=31, go to DONE.
- DONE:
  - StallE=0.
  - On the edge leaving DONE, apply the signs, write HI/LO, and return to IDLE. The held instruction leaves E on that same edge, so the operation is not restarted.
- MULT result: {HI,LO} = signed 64-bit product.
- DIV result:
  - LO = quotient, truncated toward zero.
  - HI = remainder, with the sign of the dividend.
  - Divide by zero: LO=32'hFFFFFFFF, HI=dividend; same timing as a normal divide.
- Operands are sampled once at the IDLE→BUSY edge. Later changes on the forwarding inputs are ignored.
- MFHI/MFLO in the instruction immediately after MULT/DIV sees the new HI/LO, because HI/LO are written on the edge at which that instruction enters E.

## Timing
- ALU, forwarding and WriteRegE paths: combinational, zero latency.
- MULT/DIV occupies E for 34 cycles: 1 IDLE + 32 BUSY + 1 DONE. StallE is high for exactly 33 consecutive cycles.
- Reset (asynchronous, any state, including mid-operation):
  - FSM → IDLE, counter=0, HI=LO=0.
  - Operand and accumulator registers → 0.
  - StallE is forced to 0 while reset is low.
  - The operation in flight is discarded.
- Back-to-back MULT/DIV: the second starts in IDLE on the cycle after DONE.

## Configuration
- EXEC_DIV_EN defined: DIV (code 9) is implemented as described above.
- EXEC_DIV_EN undefined:
  - Code 9 behaves as an unused code: ALUOutE=0, no stall, HI/LO unchanged.
  - All divider logic is removed.
  - MULT is unaffected.

## Structure
- Shared package holds:
  - ALU opcode localparams (ALU_AND … ALU_MFLO).
  - Forward-select encodings (FWD_RF, FWD_MEM, FWD_WB).
  - md FSM state encoding (MD_IDLE, MD_BUSY, MD_DONE).
- Sub-module md_unit: FSM, counter, iterative multiply/divide datapath, HI/LO registers. Its ports are start, op, a, b, busy, hi, lo, plus clock and reset.
- execute_stage contains the forwarding muxes, the ALU, the RegDst mux, and one md_unit instance.

## Test plan
- ADD with ForwardAE=10, ALUOutM=5, RD2_E=7, ALUSrcE=0 → ALUOutE=12, WriteDataE=7.
- SLT, SrcA=32'hFFFFFFFF, SrcB=1 → ALUOutE=1. SUB 0−1 → 32'hFFFFFFFF. RegDstE=1, RdE=9 → WriteRegE=9.
- MULT −3×7 → StallE high exactly 33 cycles. Following MFLO reads 32'hFFFFFFEB; MFHI reads 32'hFFFFFFFF.
- DIV 7÷−2 → LO=32'hFFFFFFFD, HI=1. DIV 5÷0 → LO=32'hFFFFFFFF, HI=5, StallE high 33 cycles.
- Reset asserted at BUSY count=10 → StallE=0 immediately and HI=LO=0. After release, MFLO returns 0 and a new MULT 2×3 gives LO=6.
- Build without EXEC_DIV_EN: DIV 8÷2 → StallE never asserted, HI/LO keep their previous values.

Source files
------------

// File: rtl/execute_stage_pkg.sv
// Shared encodings for the execute stage: ALU opcodes, forward selects, md FSM states.
package execute_stage_pkg;

    localparam logic [3:0] ALU_AND  = 4'h0;
    localparam logic [3:0] ALU_OR   = 4'h1;
    localparam logic [3:0] ALU_ADD  = 4'h2;
    localparam logic [3:0] ALU_XOR  = 4'h3;
    localparam logic [3:0] ALU_NOR  = 4'h4;
    localparam logic [3:0] ALU_SUB  = 4'h6;
    localparam logic [3:0] ALU_SLT  = 4'h7;
    localparam logic [3:0] ALU_MULT = 4'h8;
    localparam logic [3:0] ALU_DIV  = 4'h9;
    localparam logic [3:0] ALU_MFHI = 4'hA;
    localparam logic [3:0] ALU_MFLO = 4'hB;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b01;

    typedef enum logic [1:0] {MD_IDLE, MD_BUSY, MD_DONE} md_state_t;

    function automatic logic [31:0] abs32(input logic [31:0] v);
        return v[31] ? (32'd0 - v) : v;
    endfunction

    function automatic logic [31:0] fwd(input logic [1:0] sel, input logic [31:0] rf,
                                        input logic [31:0] mem, input logic [31:0] wb);
        case (sel)
            FWD_MEM: return mem;
            FWD_WB:  return wb;
            default: return rf;
        endcase
    endfunction

endpackage

// File: rtl/execute_stage_md_unit.sv
// Iterative signed multiply/divide with HI/LO registers (divider present only with EXEC_DIV_EN).
module md_unit
    import execute_stage_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    md_state_t   state, state_next;
    logic [4:0]  count;
    logic [31:0] mag_b;
    logic [63:0] acc, acc_step, prod;
    logic [31:0] hi_res, lo_res;
    logic [32:0] sum;
    logic        neg_q, go, busy_fsm;

`ifdef EXEC_DIV_EN
    logic        op_r, neg_r, b_zero, ge;
    logic [32:0] shifted, diff;
    assign go = start;
`else
    // Without a divider a divide request is simply not accepted.
    assign go = start & ~op;
`endif

    always_comb begin
        state_next = state;
        busy_fsm   = 1'b0;
        case (state)
            MD_IDLE: if (go) begin
                busy_fsm   = 1'b1;
                state_next = MD_BUSY;
            end
            MD_BUSY: begin
                busy_fsm = 1'b1;
                if (count == 5'd31) state_next = MD_DONE;
            end
            MD_DONE: state_next = MD_IDLE;
            default: state_next = MD_IDLE;
        endcase
    end

    // The stall must drop the moment reset is asserted, not at the next edge.
    assign busy = busy_fsm & reset;

    // acc holds {partial product | remainder, multiplier | dividend/quotient}.
    always_comb begin
        sum      = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, mag_b} : 33'd0);
        acc_step = {sum, acc[31:1]};
`ifdef EXEC_DIV_EN
        shifted = {acc[63:32], acc[31]};
        ge      = shifted >= {1'b0, mag_b};
        diff    = shifted - {1'b0, mag_b};
        if (op_r) acc_step = {(ge ? diff[31:0] : shifted[31:0]), acc[30:0], ge};
`endif
    end

    always_comb begin
        prod   = neg_q ? (64'd0 - acc) : acc;
        hi_res = prod[63:32];
        lo_res = prod[31:0];
`ifdef EXEC_DIV_EN
        if (op_r) begin
            hi_res = neg_r ? (32'd0 - acc[63:32]) : acc[63:32];
            lo_res = b_zero ? 32'hFFFF_FFFF : (neg_q ? (32'd0 - acc[31:0]) : acc[31:0]);
        end
`endif
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= MD_IDLE;
            count <= 5'd0;
            acc   <= 64'd0;
            mag_b <= 32'd0;
            neg_q <= 1'b0;
            hi    <= 32'd0;
            lo    <= 32'd0;
`ifdef EXEC_DIV_EN
            op_r   <= 1'b0;
            neg_r  <= 1'b0;
            b_zero <= 1'b0;
`endif
        end else begin
            state <= state_next;
            case (state)
                MD_IDLE: if (go) begin
                    acc   <= {32'd0, abs32(a)};
                    mag_b <= abs32(b);
                    neg_q <= a[31] ^ b[31];
                    count <= 5'd0;
`ifdef EXEC_DIV_EN
                    op_r   <= op;
                    neg_r  <= a[31];
                    b_zero <= (b == 32'd0);
`endif
                end
                MD_BUSY: begin
                    acc   <= acc_step;
                    count <= count + 5'd1;
                end
                MD_DONE: begin
                    hi <= hi_res;
                    lo <= lo_res;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/execute_stage.sv
// MIPS execute stage: forwarding muxes, ALU, RegDst mux and the multiply/divide unit.
// Define EXEC_DIV_EN to include the signed divider (ALU code 9).
module execute_stage
    import execute_stage_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [3:0]       ALUControlE,
    input  logic             ALUSrcE,
    input  logic             RegDstE,
    input  logic [WIDTH-1:0] RD1_E,
    input  logic [WIDTH-1:0] RD2_E,
    input  logic [4:0]       RtE,
    input  logic [4:0]       RdE,
    input  logic [WIDTH-1:0] SignImmE,
    input  logic [1:0]       ForwardAE,
    input  logic [1:0]       ForwardBE,
    input  logic [WIDTH-1:0] ALUOutM,
    input  logic [WIDTH-1:0] ResultW,
    output logic [WIDTH-1:0] ALUOutE,
    output logic [WIDTH-1:0] WriteDataE,
    output logic [4:0]       WriteRegE,
    output logic             StallE,
    output logic [WIDTH-1:0] HiE,
    output logic [WIDTH-1:0] LoE
);
    logic [31:0] src_a, src_b;
    logic        md_start, md_op;

    assign src_a      = fwd(ForwardAE, RD1_E, ALUOutM, ResultW);
    assign WriteDataE = fwd(ForwardBE, RD2_E, ALUOutM, ResultW);
    assign src_b      = ALUSrcE ? SignImmE : WriteDataE;
    assign WriteRegE  = RegDstE ? RdE : RtE;

`ifdef EXEC_DIV_EN
    assign md_start = (ALUControlE == ALU_MULT) || (ALUControlE == ALU_DIV);
`else
    assign md_start = (ALUControlE == ALU_MULT);
`endif
    assign md_op = (ALUControlE == ALU_DIV);

    always_comb begin
        ALUOutE = 32'd0;
        case (ALUControlE)
            ALU_AND:  ALUOutE = src_a & src_b;
            ALU_OR:   ALUOutE = src_a | src_b;
            ALU_ADD:  ALUOutE = src_a + src_b;
            ALU_XOR:  ALUOutE = src_a ^ src_b;
            ALU_NOR:  ALUOutE = ~(src_a | src_b);
            ALU_SUB:  ALUOutE = src_a - src_b;
            ALU_SLT:  ALUOutE = {31'd0, $signed(src_a) < $signed(src_b)};
            ALU_MFHI: ALUOutE = HiE;
            ALU_MFLO: ALUOutE = LoE;
            default:  ALUOutE = 32'd0;
        endcase
    end

    md_unit u_md (
        .clock (clock),
        .reset (reset),
        .start (md_start),
        .op    (md_op),
        .a     (src_a),
        .b     (src_b),
        .busy  (StallE),
        .hi    (HiE),
        .lo    (LoE)
    );

endmodule
